mem_port_arbiter: RTL

- Shares one single-port external memory between the rv32 core's instruction-fetch (imem) and data (dmem) request streams.
- Sits between the core's imem/dmem interfaces and the memory model or controller.
- Arbitrates requests with dmem priority plus an imem anti-starvation override.
- Tracks outstanding requests in an in-order tag FIFO so each memory response returns to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the imem and dmem request streams onto one memory port. dmem has priority, with an imem anti-starvation override.
// An in-order tag FIFO routes each memory response back to the requester that issued it.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imem_req_valid,
    output logic        imem_req_ready,
    input  logic [31:0] imem_req_addr,
    output logic        imem_rsp_valid,
    input  logic        imem_rsp_ready,
    output logic [31:0] imem_rsp_data,
    input  logic        dmem_req_valid,
    output logic        dmem_req_ready,
    input  logic [3:0]  dmem_req_wstrb,
    input  logic [31:0] dmem_req_addr,
    input  logic [31:0] dmem_req_wdata,
    output logic        dmem_rsp_valid,
    input  logic        dmem_rsp_ready,
    output logic [31:0] dmem_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [3:0]  mem_req_wstrb,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_data
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] EMPTY_CNT  = {CNT_W{1'b0}};
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);
    localparam logic             TAG_IMEM   = 1'b0;

    logic [MAX_OUTSTANDING-1:0] tag_mem_r;
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic [STV_W-1:0]           starve_r;

    logic grant_i_s;
    logic grant_d_s;
    logic fifo_full_s;
    logic fifo_empty_s;
    logic head_s;
    logic push_s;
    logic pop_s;

    // Arbitration decision and FIFO status flags
    always_comb begin
        fifo_full_s  = (count_r == FULL_CNT);
        fifo_empty_s = (count_r == EMPTY_CNT);
        grant_i_s    = imem_req_valid && (!dmem_req_valid || (starve_r == STARVE_MAX));
        grant_d_s    = dmem_req_valid && !grant_i_s;
        head_s       = tag_mem_r[rd_ptr_r];
    end

    // Request-side muxing toward memory; imem never writes
    always_comb begin
        mem_req_valid  = (imem_req_valid || dmem_req_valid) && !fifo_full_s;
        imem_req_ready = grant_i_s && mem_req_ready && !fifo_full_s;
        dmem_req_ready = grant_d_s && mem_req_ready && !fifo_full_s;
        if (grant_i_s) begin
            mem_req_addr  = imem_req_addr;
            mem_req_wstrb = 4'h0;
            mem_req_wdata = 32'h0000_0000;
        end else begin
            mem_req_addr  = dmem_req_addr;
            mem_req_wstrb = dmem_req_wstrb;
            mem_req_wdata = dmem_req_wdata;
        end
        push_s = mem_req_valid && mem_req_ready;
    end

    // Response routing by head tag; an empty FIFO swallows nothing and raises nothing
    always_comb begin
        if (fifo_empty_s) begin
            mem_rsp_ready  = 1'b0;
            imem_rsp_valid = 1'b0;
            dmem_rsp_valid = 1'b0;
        end else if (head_s == TAG_IMEM) begin
            mem_rsp_ready  = imem_rsp_ready;
            imem_rsp_valid = mem_rsp_valid;
            dmem_rsp_valid = 1'b0;
        end else begin
            mem_rsp_ready  = dmem_rsp_ready;
            imem_rsp_valid = 1'b0;
            dmem_rsp_valid = mem_rsp_valid;
        end
        imem_rsp_data = mem_rsp_data;
        dmem_rsp_data = mem_rsp_data;
        pop_s         = mem_rsp_valid && mem_rsp_ready;
    end

    // Tag FIFO storage and pointers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_mem_r <= {MAX_OUTSTANDING{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= grant_d_s;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Outstanding-request count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_r <= EMPTY_CNT;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Anti-starvation counter: saturates and holds until imem is accepted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_r <= {STV_W{1'b0}};
        end else if (!imem_req_valid || imem_req_ready) begin
            starve_r <= {STV_W{1'b0}};
        end else if (starve_r != STARVE_MAX) begin
            starve_r <= starve_r + STV_W'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule
